gray_center_param: RTL and testbench
====================================

GRAY_CENTER_PARAM -- requirements
Module: gray_center_param

Interface
REQ-001 SHALL provide parameter PIX_W, 8, pixel gray width.
REQ-002 SHALL provide parameter WIN_DEPTH, 101, samples per column window.
REQ-003 SHALL provide parameter IMG_WIDTH, 640, columns per frame.
REQ-004 SHALL provide parameter Y_BASE, 235, row coordinate of the first window sample.
REQ-005 SHALL provide parameter X_W, 11, column coordinate width.
REQ-006 SHALL provide parameter Y_W, 10, integer row coordinate width.
REQ-007 SHALL provide parameter FRAC_W, 4, sub-pixel fraction bits of center_y.
REQ-008 SHALL provide port clk, input, 1, single clock; all logic on its rising edge.
REQ-009 SHALL provide port rst_n, input, 1, reset, asynchronous and active-low.
REQ-010 SHALL provide port start, input, 1, pulse: threshold ready, begin frame.
REQ-011 SHALL provide port thresh, input, PIX_W, threshold; sampled on accepted start.
REQ-012 SHALL provide port mode, input, 2, weight select; sampled on accepted start.
REQ-013 SHALL provide port pix_req, output, 1, block ready to take a pixel.
REQ-014 SHALL provide port pix_valid, input, 1, pix_data valid.
REQ-015 SHALL provide port pix_data, input, PIX_W, gray sample, rows in ascending order.
REQ-016 SHALL provide port center_x, output, X_W, column index, first column = 1.
REQ-017 SHALL provide port center_y, output, Y_W+FRAC_W, fixed-point row centroid.
REQ-018 SHALL provide port center_valid, output, 1, one-cycle result strobe.
REQ-019 SHALL provide port center_miss, output, 1, no weighted sample in column; qualified by center_valid.
REQ-020 SHALL provide port busy, output, 1, high from accepted start until frame_done.
REQ-021 SHALL provide port frame_done, output, 1, one-cycle end-of-frame pulse.

Function
REQ-022 SHALL implement states IDLE, LOAD, DIV, OUT, DONE; IDLE->LOAD on start, start ignored when not IDLE.
REQ-023 SHALL assert pix_req only in LOAD; accept a sample on a cycle with pix_req and pix_valid high; pix_valid low stalls without side effects.
REQ-024 SHALL assign row y = Y_BASE + k to the k-th accepted sample, k = 0..WIN_DEPTH-1.
REQ-025 SHALL weight samples with g < thresh as 0; otherwise mode 00: g, 01: g*g, 10: g-thresh, 11: (g-thresh)^2.
REQ-026 SHALL accumulate den = sum(w) and num = sum(w*y) at full width with no overflow, both cleared at LOAD entry.
REQ-027 SHALL go LOAD->DIV on the last window sample when den != 0 (after including that sample), else LOAD->OUT with center_miss = 1 and center_y = 0.
REQ-028 SHALL compute center_y = floor((num << FRAC_W) / den) with a bit-serial restoring divider, one quotient bit per cycle, Y_W+FRAC_W cycles; results exceeding the range saturate to all ones.
REQ-029 SHALL pulse center_valid in OUT, exactly Y_W+FRAC_W+1 cycles after the last-sample edge (1 cycle on miss); center_x/center_y/center_miss hold until the next result.
REQ-030 SHALL go OUT->LOAD when center_x < IMG_WIDTH, else OUT->DONE; DONE pulses frame_done for one cycle, returns to IDLE, clears busy.
REQ-031 SHALL consume no pixels and keep pix_req low in DIV, OUT, DONE.

Reset
REQ-032 SHALL, while rst_n is low, force state IDLE, all accumulators 0, and all outputs 0, including mid-column and mid-division.
REQ-033 SHALL, after reset release, require a new start; no partial result is emitted.

Verification (WIN_DEPTH=4, IMG_WIDTH=2, Y_BASE=10, FRAC_W=4, Y_W=10)
REQ-034 SHALL cover mode 01, thresh 50, pixels 0,100,100,0 -> center_y 184 (11.5), center_miss 0, center_x 1.
REQ-035 SHALL cover mode 10, thresh 50, pixels 50,70,90,0 -> center_y 186; mode 00, pixels 60,0,0,20 -> center_y 160.
REQ-036 SHALL cover all-zero column -> center_valid pulse 1 cycle after last sample, center_miss 1, center_y 0.
REQ-037 SHALL cover pix_valid toggled every other cycle -> identical results and only accepted samples counted.
REQ-038 SHALL cover a two-column frame -> center_x 1 then 2, frame_done one cycle after second center_valid, busy low after; start during busy ignored.
REQ-039 SHALL cover rst_n low mid-division -> outputs 0 immediately, no center_valid, new start yields correct frame.

Source files
------------

// File: rtl/gray_center_param.sv
// rtl/gray_center_param.sv - per-column thresholded gray centroid with bit-serial restoring divider
module gray_center_param #(
   parameter int PIX_W     = 8,
   parameter int WIN_DEPTH = 101,
   parameter int IMG_WIDTH = 640,
   parameter int Y_BASE    = 235,
   parameter int X_W       = 11,
   parameter int Y_W       = 10,
   parameter int FRAC_W    = 4
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [PIX_W-1:0]        thresh,
   input  logic [1:0]              mode,
   output logic                    pix_req,
   input  logic                    pix_valid,
   input  logic [PIX_W-1:0]        pix_data,
   output logic [X_W-1:0]          center_x,
   output logic [Y_W+FRAC_W-1:0]   center_y,
   output logic                    center_valid,
   output logic                    center_miss,
   output logic                    busy,
   output logic                    frame_done
);
   localparam int Q_W   = Y_W + FRAC_W;
   localparam int W_W   = 2 * PIX_W;
   localparam int Y_MAX = Y_BASE + WIN_DEPTH - 1;
   localparam int YR_W  = $clog2(Y_MAX + 1);
   localparam int DEN_W = W_W + $clog2(WIN_DEPTH + 1);
   localparam int NUM_W = DEN_W + YR_W;
   localparam int D_W   = NUM_W + FRAC_W;
   localparam int C_W   = $clog2(Q_W);

   typedef enum logic [2:0] {IDLE, LOAD, DIV, OUT, DONE} state_t;

   state_t              state;
   logic [PIX_W-1:0]    thr_r;
   logic [1:0]          mode_r;
   logic [YR_W-1:0]     yrow;
   logic [DEN_W-1:0]    den;
   logic [NUM_W-1:0]    num;
   logic [X_W-1:0]      col;
   logic                miss_r;
   logic                sat_r;
   logic [DEN_W-1:0]    rem;
   logic [Q_W-1:0]      lo;
   logic [Q_W-1:0]      quot;
   logic [C_W-1:0]      cnt;

   logic [PIX_W-1:0]    base;
   logic [W_W-1:0]      w;
   logic [DEN_W-1:0]    den_nxt;
   logic [NUM_W-1:0]    num_nxt;
   logic [D_W-1:0]      dvd;
   logic [D_W-1:0]      hi;
   logic                sat_now;
   logic [DEN_W-1:0]    rem_cur;
   logic [Q_W-1:0]      lo_cur;
   logic [DEN_W:0]      trial;
   logic                ge;
   logic [DEN_W-1:0]    rem_nxt;

   always_comb begin
      base    = mode_r[1] ? (pix_data - thr_r) : pix_data;
      w       = '0;
      if (pix_data >= thr_r)
         w = mode_r[0] ? W_W'(base) * W_W'(base) : W_W'(base);
      den_nxt = den + DEN_W'(w);
      num_nxt = num + NUM_W'(w) * NUM_W'(yrow);
   end

   // The quotient fits Q_W bits iff (num<<FRAC_W)>>Q_W < den, so that top part seeds the remainder.
   always_comb begin
      dvd     = {num, {FRAC_W{1'b0}}};
      hi      = dvd >> Q_W;
      sat_now = hi >= D_W'(den);
      rem_cur = (cnt == '0) ? hi[DEN_W-1:0] : rem;
      lo_cur  = (cnt == '0) ? dvd[Q_W-1:0] : lo;
      trial   = {rem_cur, lo_cur[Q_W-1]};
      ge      = trial >= {1'b0, den};
      rem_nxt = ge ? DEN_W'(trial - {1'b0, den}) : DEN_W'(trial);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         thr_r        <= '0;
         mode_r       <= '0;
         yrow         <= '0;
         den          <= '0;
         num          <= '0;
         col          <= '0;
         miss_r       <= 1'b0;
         sat_r        <= 1'b0;
         rem          <= '0;
         lo           <= '0;
         quot         <= '0;
         cnt          <= '0;
         pix_req      <= 1'b0;
         center_x     <= '0;
         center_y     <= '0;
         center_valid <= 1'b0;
         center_miss  <= 1'b0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         center_valid <= 1'b0;
         frame_done   <= 1'b0;
         case (state)
            IDLE: if (start) begin
               thr_r   <= thresh;
               mode_r  <= mode;
               busy    <= 1'b1;
               col     <= X_W'(1);
               num     <= '0;
               den     <= '0;
               yrow    <= YR_W'(Y_BASE);
               miss_r  <= 1'b0;
               pix_req <= 1'b1;
               state   <= LOAD;
            end
            LOAD: if (pix_valid) begin
               den  <= den_nxt;
               num  <= num_nxt;
               yrow <= yrow + YR_W'(1);
               if (yrow == YR_W'(Y_MAX)) begin
                  pix_req <= 1'b0;
                  cnt     <= '0;
                  miss_r  <= (den_nxt == '0);
                  state   <= (den_nxt == '0) ? OUT : DIV;
               end
            end
            DIV: begin
               rem  <= rem_nxt;
               lo   <= {lo_cur[Q_W-2:0], 1'b0};
               quot <= {quot[Q_W-2:0], ge};
               if (cnt == '0)
                  sat_r <= sat_now;
               cnt  <= cnt + C_W'(1);
               if (cnt == C_W'(Q_W - 1))
                  state <= OUT;
            end
            OUT: begin
               center_valid <= 1'b1;
               center_x     <= col;
               center_miss  <= miss_r;
               center_y     <= miss_r ? '0 : (sat_r ? '1 : quot);
               if (col < X_W'(IMG_WIDTH)) begin
                  col     <= col + X_W'(1);
                  num     <= '0;
                  den     <= '0;
                  yrow    <= YR_W'(Y_BASE);
                  miss_r  <= 1'b0;
                  pix_req <= 1'b1;
                  state   <= LOAD;
               end else begin
                  state <= DONE;
               end
            end
            DONE: begin
               frame_done <= 1'b1;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gray_center_param.sv
// tb/tb_gray_center_param.sv - scoreboard bench for gray_center_param
module tb_gray_center_param;
   localparam int PIX_W = 8, WIN_DEPTH = 4, IMG_WIDTH = 2, Y_BASE = 10;
   localparam int X_W = 11, Y_W = 10, FRAC_W = 4;
   localparam int Q_W = Y_W + FRAC_W;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  start = 1'b0;
   logic [PIX_W-1:0]      thresh = '0;
   logic [1:0]            mode = '0;
   logic                  pix_req;
   logic                  pix_valid = 1'b0;
   logic [PIX_W-1:0]      pix_data = '0;
   logic [X_W-1:0]        center_x;
   logic [Y_W+FRAC_W-1:0] center_y;
   logic                  center_valid, center_miss, busy, frame_done;

   gray_center_param #(.PIX_W(PIX_W), .WIN_DEPTH(WIN_DEPTH), .IMG_WIDTH(IMG_WIDTH),
      .Y_BASE(Y_BASE), .X_W(X_W), .Y_W(Y_W), .FRAC_W(FRAC_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .thresh(thresh), .mode(mode),
      .pix_req(pix_req), .pix_valid(pix_valid), .pix_data(pix_data),
      .center_x(center_x), .center_y(center_y), .center_valid(center_valid),
      .center_miss(center_miss), .busy(busy), .frame_done(frame_done));

   always #5 clk = ~clk;

   typedef struct { int x; int y; bit miss; int last_cyc; } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0, passes = 0;
   int   cyc = 0, last_cv = -100, frames_done = 0;
   bit   busy_chk = 0;
   int   pix_buf [IMG_WIDTH*WIN_DEPTH];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act == req) passes++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   // Centroid straight from the weighting rules, in plain integer arithmetic.
   function automatic exp_t model(input int c, input int md, input int th);
      longint den = 0, num = 0, w, q;
      int g;
      exp_t e;
      for (int k = 0; k < WIN_DEPTH; k++) begin
         g = pix_buf[c*WIN_DEPTH+k];
         if (g < th) w = 0;
         else case (md)
            0: w = g;
            1: w = g * g;
            2: w = g - th;
            default: w = (g - th) * (g - th);
         endcase
         den += w;
         num += w * (Y_BASE + k);
      end
      e.x = c + 1;
      e.miss = (den == 0);
      e.y = 0;
      if (den != 0) begin
         q = (num * (1 << FRAC_W)) / den;
         e.y = (q > (1 << Q_W) - 1) ? (1 << Q_W) - 1 : int'(q);
      end
      e.last_cyc = 0;
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (busy_chk) begin
            check("busy_after_done", busy, 0);
            busy_chk = 0;
         end
         if (center_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_result: got center_x %0d center_y %0d, required no center_valid",
                        center_x, center_y);
            end else begin
               mon_e = exp_q.pop_front();
               check("center_x", center_x, mon_e.x);
               check("center_y", center_y, mon_e.y);
               check("center_miss", center_miss, mon_e.miss);
               check("result_latency", cyc - mon_e.last_cyc, mon_e.miss ? 1 : Q_W + 1);
               last_cv = cyc;
            end
         end
         if (frame_done) begin
            check("frame_done_delay", cyc - last_cv, 1);
            busy_chk = 1;
            frames_done++;
         end
      end
   end

   task automatic set_col(input int c, input int a, input int b, input int d, input int e);
      pix_buf[c*WIN_DEPTH+0] = a;
      pix_buf[c*WIN_DEPTH+1] = b;
      pix_buf[c*WIN_DEPTH+2] = d;
      pix_buf[c*WIN_DEPTH+3] = e;
   endtask

   task automatic feed_col(input int c, input int md, input int th, input int vmode);
      exp_t e;
      int   idx = 0, guard = 0;
      bit   tog = 0, v;
      e = model(c, md, th);
      while (idx < WIN_DEPTH) begin
         @(negedge clk);
         case (vmode)
            0: v = 1;
            1: begin v = tog; tog = ~tog; end
            default: v = 1'($urandom_range(0, 1));
         endcase
         pix_valid = v;
         pix_data  = v ? PIX_W'(pix_buf[c*WIN_DEPTH+idx]) : PIX_W'($urandom);
         if (v && pix_req) begin
            if (idx == WIN_DEPTH - 1) begin
               e.last_cyc = cyc + 1;
               exp_q.push_back(e);
            end
            idx++;
         end
         guard++;
         if (guard > 200) begin
            checks++;
            $display("FAIL pix_req_timeout col %0d: accepted %0d, required %0d", c, idx, WIN_DEPTH);
            break;
         end
      end
   endtask

   task automatic run_frame(input int md, input int th, input int vmode, input bit poke);
      int fd0 = frames_done, guard = 0;
      @(negedge clk);
      thresh = PIX_W'(th); mode = 2'(md); start = 1'b1; pix_valid = 1'b0;
      @(negedge clk);
      start = 1'b0; thresh = PIX_W'($urandom); mode = 2'($urandom);
      check("busy_after_start", busy, 1);
      for (int c = 0; c < IMG_WIDTH; c++) begin
         feed_col(c, md, th, vmode);
         if (poke && c == 0) begin
            @(negedge clk); pix_valid = 1'b0; start = 1'b1;
            @(negedge clk); start = 1'b0;
         end
      end
      @(negedge clk); pix_valid = 1'b0;
      while (frames_done == fd0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (frames_done == fd0) begin
         checks++;
         $display("FAIL frame_done_timeout: got no frame_done, required one");
      end
      check("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_pix_req", pix_req, 0);
      check("reset_busy", busy, 0);
      check("reset_center_valid", center_valid, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      set_col(0, 0, 100, 100, 0);
      set_col(1, 0, 0, 0, 0);
      run_frame(1, 50, 0, 0);

      set_col(0, 50, 70, 90, 0);
      set_col(1, 255, 255, 255, 255);
      run_frame(2, 50, 0, 1);

      set_col(0, 60, 0, 0, 20);
      set_col(1, 10, 200, 30, 90);
      run_frame(0, 50, 1, 0);

      for (int f = 0; f < 8; f++) begin
         for (int i = 0; i < IMG_WIDTH*WIN_DEPTH; i++)
            pix_buf[i] = (f == 5 && i < WIN_DEPTH) ? 0 : int'($urandom_range(0, 255));
         run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 200)),
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      set_col(0, 60, 80, 100, 120);
      set_col(1, 1, 2, 3, 4);
      @(negedge clk);
      thresh = 8'd50; mode = 2'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      feed_col(0, 3, 50, 0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_center_x", center_x, 0);
      check("rst_center_y", center_y, 0);
      check("rst_center_miss", center_miss, 0);
      check("rst_busy", busy, 0);
      check("rst_pix_req", pix_req, 0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      pix_valid = 1'b1;
      repeat (4) @(negedge clk);
      check("no_restart_busy", busy, 0);
      check("no_restart_pix_req", pix_req, 0);
      pix_valid = 1'b0;
      run_frame(3, 50, 2, 0);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
